// File: rtl/vec_mem_seq.sv
// vec_mem_seq: vector load/store sequencer driving the multi-port vector
// data memory (4 write-data ports, 8 read-data ports, word addresses).
//
// Accepts one request (base word address, beat count, direction) in IDLE
// and walks it beat by beat:
//   store: each st_valid/st_ready handshake writes 4 words on the next cycle
//   load : each capture reads 8 words and presents them on ld_data
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   start, op, base, beats    request strobe, 0=load/1=store, first word address,
//                             beat count (clamped to MAX_BEATS)
//   busy, done                request in flight, one-cycle completion pulse
//   st_valid, st_ready,       store-data handshake, 4 words packed
//   st_data                   (word k in bits [32k+31:32k])
//   ld_valid, ld_ready,       load-data handshake, 8 words packed the same way
//   ld_data
//   mem_we, mem_wr_addr,      memory write port (registered)
//   mem_wd1..mem_wd4
//   mem_rd_addr, mem_rd1..8   memory read port; read data is combinational
//
// Configuration
//   VEC_MEM_SEQ_STRIDE_EN     when defined, adds a 16-bit `stride` input
//                             (word units) used as the per-beat increment for
//                             both directions; otherwise the increment is 4
//                             for stores and 8 for loads.
module vec_mem_seq #(
  parameter  int unsigned MAX_BEATS = 16,
  localparam int unsigned BEATS_W   = $clog2(MAX_BEATS + 1),
  localparam int unsigned WORD_W    = 32,
  localparam int unsigned ST_WORDS  = 4,
  localparam int unsigned LD_WORDS  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         op,
  input  logic [WORD_W-1:0]            base,
  input  logic [BEATS_W-1:0]           beats,
`ifdef VEC_MEM_SEQ_STRIDE_EN
  input  logic [15:0]                  stride,
`endif
  output logic                         busy,
  output logic                         done,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [ST_WORDS*WORD_W-1:0]   st_data,
  output logic                         ld_valid,
  input  logic                         ld_ready,
  output logic [LD_WORDS*WORD_W-1:0]   ld_data,
  output logic                         mem_we,
  output logic [WORD_W-1:0]            mem_wr_addr,
  output logic [WORD_W-1:0]            mem_rd_addr,
  output logic [WORD_W-1:0]            mem_wd1,
  output logic [WORD_W-1:0]            mem_wd2,
  output logic [WORD_W-1:0]            mem_wd3,
  output logic [WORD_W-1:0]            mem_wd4,
  input  logic [WORD_W-1:0]            mem_rd1,
  input  logic [WORD_W-1:0]            mem_rd2,
  input  logic [WORD_W-1:0]            mem_rd3,
  input  logic [WORD_W-1:0]            mem_rd4,
  input  logic [WORD_W-1:0]            mem_rd5,
  input  logic [WORD_W-1:0]            mem_rd6,
  input  logic [WORD_W-1:0]            mem_rd7,
  input  logic [WORD_W-1:0]            mem_rd8
);

  localparam int unsigned ST_INC = 4;
  localparam int unsigned LD_INC = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    LOAD  = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                              state_q, state_d;
  logic [WORD_W-1:0]                   addr_q, addr_d;
  logic [BEATS_W-1:0]                  cnt_q, cnt_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic                                st_ready_q, st_ready_d;
  logic                                ld_valid_q, ld_valid_d;
  logic [LD_WORDS*WORD_W-1:0]          ld_data_q, ld_data_d;
  logic                                mem_we_q, mem_we_d;
  logic [WORD_W-1:0]                   wr_addr_q, wr_addr_d;
  logic [ST_WORDS-1:0][WORD_W-1:0]     wd_q, wd_d;

  logic [BEATS_W-1:0]                  beats_clamp_c;
  logic [WORD_W-1:0]                   inc_c;
  logic [LD_WORDS*WORD_W-1:0]          rd_words_c;

  // Out-of-range beat counts saturate at MAX_BEATS.
  always_comb begin
    beats_clamp_c = beats;
    if (beats > BEATS_W'(MAX_BEATS)) begin
      beats_clamp_c = BEATS_W'(MAX_BEATS);
    end
  end

`ifdef VEC_MEM_SEQ_STRIDE_EN
  logic [15:0] stride_q, stride_d;

  always_comb begin
    stride_d = stride_q;
    if (state_q == IDLE && start) begin
      stride_d = stride;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stride_q <= 16'd0;
    end else begin
      stride_q <= stride_d;
    end
  end

  assign inc_c = WORD_W'(stride_q);
`else
  // Direction is implied by the active state, so no op register is kept.
  assign inc_c = (state_q == STORE) ? WORD_W'(ST_INC) : WORD_W'(LD_INC);
`endif

  assign rd_words_c = {mem_rd8, mem_rd7, mem_rd6, mem_rd5,
                       mem_rd4, mem_rd3, mem_rd2, mem_rd1};

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    st_ready_d = st_ready_q;
    ld_valid_d = ld_valid_q;
    ld_data_d  = ld_data_q;
    mem_we_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wd_d       = wd_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base;
          cnt_d  = beats_clamp_c;
          if (beats_clamp_c == '0) begin
            state_d = FIN;
          end else if (op) begin
            state_d    = STORE;
            st_ready_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end

      STORE: begin
        // The cycle with the counter at zero lets the final write retire
        // before the done pulse.
        if (cnt_q == '0) begin
          state_d = FIN;
        end else if (st_valid && st_ready_q) begin
          mem_we_d  = 1'b1;
          wr_addr_d = addr_q;
          wd_d      = st_data;
          addr_d    = addr_q + inc_c;
          cnt_d     = cnt_q - BEATS_W'(1);
          if (cnt_q == BEATS_W'(1)) begin
            st_ready_d = 1'b0;
          end
        end
      end

      LOAD: begin
        // The output register is free when empty or being drained.
        if (!ld_valid_q || ld_ready) begin
          if (cnt_q != '0) begin
            ld_data_d  = rd_words_c;
            ld_valid_d = 1'b1;
            addr_d     = addr_q + inc_c;
            cnt_d      = cnt_q - BEATS_W'(1);
          end else begin
            ld_valid_d = 1'b0;
            state_d    = FIN;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN) && (state_q != FIN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      st_ready_q <= 1'b0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      mem_we_q   <= 1'b0;
      wr_addr_q  <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      st_ready_q <= st_ready_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      mem_we_q   <= mem_we_d;
      wr_addr_q  <= wr_addr_d;
      wd_q       <= wd_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign st_ready    = st_ready_q;
  assign ld_valid    = ld_valid_q;
  assign ld_data     = ld_data_q;
  assign mem_we      = mem_we_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_rd_addr = addr_q;
  assign mem_wd1     = wd_q[0];
  assign mem_wd2     = wd_q[1];
  assign mem_wd3     = wd_q[2];
  assign mem_wd4     = wd_q[3];

endmodule

// File: tb/tb_vec_mem_seq.sv
// tb_vec_mem_seq: directed bench for vec_mem_seq with a 64-word read model.
module tb_vec_mem_seq;

  logic         clk;
  logic         rst_i;
  logic         start_i;
  logic         op_i;
  logic [31:0]  base_i;
  logic [4:0]   beats_i;
`ifdef VEC_MEM_SEQ_STRIDE_EN
  logic [15:0]  stride_i;
`endif
  logic         busy, done;
  logic         st_valid_i, st_ready;
  logic [127:0] st_data_i;
  logic         ld_valid, ld_ready_i;
  logic [255:0] ld_data;
  logic         mem_we;
  logic [31:0]  mem_wr_addr, mem_rd_addr;
  logic [31:0]  mem_wd1, mem_wd2, mem_wd3, mem_wd4;
  logic [31:0]  mem_rd1, mem_rd2, mem_rd3, mem_rd4;
  logic [31:0]  mem_rd5, mem_rd6, mem_rd7, mem_rd8;

  logic [31:0]  ram [64];

  int checks;
  int failures;

  // Observations gathered by the run tasks.
  int           we_cnt, done_cnt, done_cyc, ld_seen, acc, first_v, last_acc, stable_bad;
  logic         busy_c1, busy_after;
  logic [31:0]  obs_addr [20];
  logic [127:0] obs_data [20];
  logic [255:0] ld_obs [8];
  logic [31:0]  rd_addr_c1, rd_addr_end;
  logic [127:0] st_beats [4];

  vec_mem_seq dut (
    .clk(clk), .rst(rst_i), .start(start_i), .op(op_i), .base(base_i), .beats(beats_i),
`ifdef VEC_MEM_SEQ_STRIDE_EN
    .stride(stride_i),
`endif
    .busy(busy), .done(done),
    .st_valid(st_valid_i), .st_ready(st_ready), .st_data(st_data_i),
    .ld_valid(ld_valid), .ld_ready(ld_ready_i), .ld_data(ld_data),
    .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
    .mem_wd1(mem_wd1), .mem_wd2(mem_wd2), .mem_wd3(mem_wd3), .mem_wd4(mem_wd4),
    .mem_rd1(mem_rd1), .mem_rd2(mem_rd2), .mem_rd3(mem_rd3), .mem_rd4(mem_rd4),
    .mem_rd5(mem_rd5), .mem_rd6(mem_rd6), .mem_rd7(mem_rd7), .mem_rd8(mem_rd8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd1 = ram[mem_rd_addr[5:0]];
  assign mem_rd2 = ram[6'(mem_rd_addr[5:0] + 6'd1)];
  assign mem_rd3 = ram[6'(mem_rd_addr[5:0] + 6'd2)];
  assign mem_rd4 = ram[6'(mem_rd_addr[5:0] + 6'd3)];
  assign mem_rd5 = ram[6'(mem_rd_addr[5:0] + 6'd4)];
  assign mem_rd6 = ram[6'(mem_rd_addr[5:0] + 6'd5)];
  assign mem_rd7 = ram[6'(mem_rd_addr[5:0] + 6'd6)];
  assign mem_rd8 = ram[6'(mem_rd_addr[5:0] + 6'd7)];

  // Expected load beat: ram[i] holds 0x1000_0000 + i.
  function automatic logic [255:0] exp_ld(input logic [31:0] a);
    logic [255:0] e;
    for (int j = 0; j < 8; j++) e[32*j +: 32] = 32'h1000_0000 + a + 32'(j);
    return e;
  endfunction

  // Drives one store request; ign_cyc > 0 pulses a load start mid-request.
  task automatic run_store(input logic [31:0] b, input logic [4:0] nb, input int ign_cyc);
    int sent;
    sent = 0; we_cnt = 0; done_cnt = 0; done_cyc = -1; ld_seen = 0;
    busy_c1 = 1'b0; busy_after = 1'b1;
    op_i = 1'b1; base_i = b; beats_i = nb; start_i = 1'b1;
`ifdef VEC_MEM_SEQ_STRIDE_EN
    stride_i = 16'd4;
`endif
    st_valid_i = 1'b1; st_data_i = st_beats[0];
    @(negedge clk);
    start_i = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 1) busy_c1 = busy;
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
      if (mem_we) begin
        if (we_cnt < 20) begin
          obs_addr[we_cnt] = mem_wr_addr;
          obs_data[we_cnt] = {mem_wd4, mem_wd3, mem_wd2, mem_wd1};
        end
        we_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (ld_valid) ld_seen++;
      st_data_i = st_beats[sent % 4];
      if (st_ready) sent++;
      if (cyc == ign_cyc) begin
        start_i = 1'b1; op_i = 1'b0; base_i = 32'h30; beats_i = 5'd5;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
    end
    st_valid_i = 1'b0;
  endtask

  // Drives one load request; ld_ready low for stall_len cycles from first ld_valid.
  task automatic run_load(input logic [31:0] b, input logic [4:0] nb, input int stall_len);
    logic         prev_hold;
    logic [255:0] prev_data;
    acc = 0; first_v = -1; last_acc = -1; done_cnt = 0; done_cyc = -1; stable_bad = 0;
    prev_hold = 1'b0; prev_data = '0; rd_addr_c1 = '0;
    op_i = 1'b0; base_i = b; beats_i = nb; start_i = 1'b1; ld_ready_i = 1'b1;
`ifdef VEC_MEM_SEQ_STRIDE_EN
    stride_i = 16'd8;
`endif
    @(negedge clk);
    start_i = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 1) rd_addr_c1 = mem_rd_addr;
      if (ld_valid && first_v < 0) first_v = cyc;
      if (prev_hold && ld_valid && ld_data !== prev_data) stable_bad++;
      ld_ready_i = !(first_v >= 0 && cyc < first_v + stall_len);
      if (ld_valid && ld_ready_i) begin
        if (acc < 8) ld_obs[acc] = ld_data;
        acc++;
        last_acc = cyc;
      end
      prev_hold = ld_valid && !ld_ready_i;
      prev_data = ld_data;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(negedge clk);
    end
    rd_addr_end = mem_rd_addr;
    ld_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", done); end
    checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL reset_st_ready got=%0h exp=0", st_ready); end
    checks++; if (ld_valid !== 1'b0) begin failures++; $display("FAIL reset_ld_valid got=%0h exp=0", ld_valid); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
    checks++; if (mem_wr_addr !== 32'h0) begin failures++; $display("FAIL reset_wr_addr got=%0h exp=0", mem_wr_addr); end
    checks++; if (mem_rd_addr !== 32'h0) begin failures++; $display("FAIL reset_rd_addr got=%0h exp=0", mem_rd_addr); end
    checks++; if ({mem_wd4, mem_wd3, mem_wd2, mem_wd1} !== 128'h0) begin failures++; $display("FAIL reset_wd got=%0h exp=0", {mem_wd4, mem_wd3, mem_wd2, mem_wd1}); end
    checks++; if (ld_data !== 256'h0) begin failures++; $display("FAIL reset_ld_data got=%0h exp=0", ld_data); end
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    st_beats[0] = {32'd23, 32'd11, 32'd100, 32'd50};
    st_beats[1] = {32'd4, 32'd3, 32'd2, 32'd1};
    run_store(32'h0, 5'd2, -1);
    checks++; if (busy_c1 !== 1'b1) begin failures++; $display("FAIL store_busy_c1 got=%0h exp=1", busy_c1); end
    checks++; if (we_cnt !== 2) begin failures++; $display("FAIL store_we_cnt got=%0d exp=2", we_cnt); end
    checks++; if (obs_addr[0] !== 32'h0) begin failures++; $display("FAIL store_addr0 got=%0h exp=0", obs_addr[0]); end
    checks++; if (obs_addr[1] !== 32'h4) begin failures++; $display("FAIL store_addr1 got=%0h exp=4", obs_addr[1]); end
    checks++; if (obs_data[0] !== {32'd23, 32'd11, 32'd100, 32'd50}) begin failures++; $display("FAIL store_data0 got=%0h exp=%0h", obs_data[0], {32'd23, 32'd11, 32'd100, 32'd50}); end
    checks++; if (obs_data[1] !== {32'd4, 32'd3, 32'd2, 32'd1}) begin failures++; $display("FAIL store_data1 got=%0h exp=%0h", obs_data[1], {32'd4, 32'd3, 32'd2, 32'd1}); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL store_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (done_cyc !== 4) begin failures++; $display("FAIL store_done_cyc got=%0d exp=4", done_cyc); end
    checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL store_busy_after got=%0h exp=0", busy_after); end
  endtask

  task automatic test_load();
    run_load(32'h8, 5'd3, 0);
    checks++; if (rd_addr_c1 !== 32'h8) begin failures++; $display("FAIL load_rd_addr_c1 got=%0h exp=8", rd_addr_c1); end
    checks++; if (first_v !== 2) begin failures++; $display("FAIL load_first_valid got=%0d exp=2", first_v); end
    checks++; if (acc !== 3) begin failures++; $display("FAIL load_beats got=%0d exp=3", acc); end
    checks++; if (last_acc !== 4) begin failures++; $display("FAIL load_last_acc got=%0d exp=4", last_acc); end
    checks++; if (ld_obs[0] !== exp_ld(32'd8)) begin failures++; $display("FAIL load_data0 got=%0h exp=%0h", ld_obs[0], exp_ld(32'd8)); end
    checks++; if (ld_obs[1] !== exp_ld(32'd16)) begin failures++; $display("FAIL load_data1 got=%0h exp=%0h", ld_obs[1], exp_ld(32'd16)); end
    checks++; if (ld_obs[2] !== exp_ld(32'd24)) begin failures++; $display("FAIL load_data2 got=%0h exp=%0h", ld_obs[2], exp_ld(32'd24)); end
    checks++; if (done_cyc !== 5) begin failures++; $display("FAIL load_done_cyc got=%0d exp=5", done_cyc); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL load_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (rd_addr_end !== 32'd32) begin failures++; $display("FAIL load_rd_addr_end got=%0h exp=20", rd_addr_end); end
  endtask

  task automatic test_load_stall();
    run_load(32'h0, 5'd2, 3);
    checks++; if (stable_bad !== 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", stable_bad); end
    checks++; if (acc !== 2) begin failures++; $display("FAIL stall_beats got=%0d exp=2", acc); end
    checks++; if (ld_obs[0] !== exp_ld(32'd0)) begin failures++; $display("FAIL stall_data0 got=%0h exp=%0h", ld_obs[0], exp_ld(32'd0)); end
    checks++; if (ld_obs[1] !== exp_ld(32'd8)) begin failures++; $display("FAIL stall_data1 got=%0h exp=%0h", ld_obs[1], exp_ld(32'd8)); end
    checks++; if (last_acc !== 6) begin failures++; $display("FAIL stall_last_acc got=%0d exp=6", last_acc); end
    checks++; if (done_cyc !== 7) begin failures++; $display("FAIL stall_done_cyc got=%0d exp=7", done_cyc); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL stall_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_zero_and_ignore();
    run_store(32'h20, 5'd0, -1);
    checks++; if (we_cnt !== 0) begin failures++; $display("FAIL zero_we_cnt got=%0d exp=0", we_cnt); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (done_cyc !== 1) begin failures++; $display("FAIL zero_done_cyc got=%0d exp=1", done_cyc); end
    st_beats[0] = {32'h13, 32'h12, 32'h11, 32'h10};
    st_beats[1] = {32'h23, 32'h22, 32'h21, 32'h20};
    st_beats[2] = {32'h33, 32'h32, 32'h31, 32'h30};
    st_beats[3] = {32'h43, 32'h42, 32'h41, 32'h40};
    run_store(32'h10, 5'd3, 2);
    checks++; if (we_cnt !== 3) begin failures++; $display("FAIL ignore_we_cnt got=%0d exp=3", we_cnt); end
    checks++; if (obs_addr[2] !== 32'h18) begin failures++; $display("FAIL ignore_addr2 got=%0h exp=18", obs_addr[2]); end
    checks++; if (obs_data[2] !== {32'h33, 32'h32, 32'h31, 32'h30}) begin failures++; $display("FAIL ignore_data2 got=%0h exp=%0h", obs_data[2], {32'h33, 32'h32, 32'h31, 32'h30}); end
    checks++; if (done_cyc !== 5) begin failures++; $display("FAIL ignore_done_cyc got=%0d exp=5", done_cyc); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ignore_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (ld_seen !== 0) begin failures++; $display("FAIL ignore_ld_seen got=%0d exp=0", ld_seen); end
  endtask

  task automatic test_wrap();
    run_store(32'hFFFF_FFFC, 5'd2, -1);
    checks++; if (we_cnt !== 2) begin failures++; $display("FAIL wrap_we_cnt got=%0d exp=2", we_cnt); end
    checks++; if (obs_addr[0] !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr0 got=%0h exp=fffffffc", obs_addr[0]); end
    checks++; if (obs_addr[1] !== 32'h0) begin failures++; $display("FAIL wrap_addr1 got=%0h exp=0", obs_addr[1]); end
  endtask

  task automatic test_clamp();
    run_store(32'h100, 5'd20, -1);
    checks++; if (we_cnt !== 16) begin failures++; $display("FAIL clamp_we_cnt got=%0d exp=16", we_cnt); end
    checks++; if (obs_addr[15] !== 32'h13C) begin failures++; $display("FAIL clamp_last_addr got=%0h exp=13c", obs_addr[15]); end
    checks++; if (obs_data[5] !== {32'h23, 32'h22, 32'h21, 32'h20}) begin failures++; $display("FAIL clamp_data5 got=%0h exp=%0h", obs_data[5], {32'h23, 32'h22, 32'h21, 32'h20}); end
    checks++; if (done_cyc !== 18) begin failures++; $display("FAIL clamp_done_cyc got=%0d exp=18", done_cyc); end
  endtask

  task automatic test_reset_mid();
    int dn;
    dn = 0;
    op_i = 1'b1; base_i = 32'h40; beats_i = 5'd4; start_i = 1'b1;
`ifdef VEC_MEM_SEQ_STRIDE_EN
    stride_i = 16'd4;
`endif
    st_valid_i = 1'b1; st_data_i = {32'hD, 32'hC, 32'hB, 32'hA};
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rstmid_first_we got=%0h exp=1", mem_we); end
    rst_i = 1'b1;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rstmid_mem_we got=%0h exp=0", mem_we); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0h exp=0", busy); end
    checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL rstmid_st_ready got=%0h exp=0", st_ready); end
    checks++; if (mem_wr_addr !== 32'h0) begin failures++; $display("FAIL rstmid_wr_addr got=%0h exp=0", mem_wr_addr); end
    checks++; if (mem_wd1 !== 32'h0) begin failures++; $display("FAIL rstmid_wd1 got=%0h exp=0", mem_wd1); end
    checks++; if (mem_rd_addr !== 32'h0) begin failures++; $display("FAIL rstmid_rd_addr got=%0h exp=0", mem_rd_addr); end
    rst_i = 1'b0; st_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done || mem_we) dn++;
      @(negedge clk);
    end
    checks++; if (dn !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", dn); end
    st_beats[0] = {32'h4, 32'h3, 32'h2, 32'h1};
    run_store(32'h8, 5'd1, -1);
    checks++; if (we_cnt !== 1) begin failures++; $display("FAIL rstmid_after_we got=%0d exp=1", we_cnt); end
    checks++; if (obs_addr[0] !== 32'h8) begin failures++; $display("FAIL rstmid_after_addr got=%0h exp=8", obs_addr[0]); end
    checks++; if (done_cyc !== 3) begin failures++; $display("FAIL rstmid_after_done got=%0d exp=3", done_cyc); end
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + 32'(i);
    rst_i = 1'b1; start_i = 1'b0; op_i = 1'b0; base_i = '0; beats_i = '0;
`ifdef VEC_MEM_SEQ_STRIDE_EN
    stride_i = 16'd4;
`endif
    st_valid_i = 1'b0; st_data_i = '0; ld_ready_i = 1'b1;
    test_reset();
    test_store();
    test_load();
    test_load_stall();
    test_zero_and_ignore();
    test_wrap();
    test_clamp();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_mem_seq.md
# vec_mem_seq

Vector load/store sequencer that acts as the initiator for the multi-port vector data memory (4 write-data ports, 8 read-data ports, word-indexed addresses). It accepts one vector request from the ID/EX stage: a base word address, a beat count and a direction. It then issues beat-by-beat memory accesses with valid/ready handshakes on the register-file side. Each store beat writes 4 words; each load beat reads 8 words.

## Interface
Parameters:
- `MAX_BEATS`, default 16: largest legal beat count; `beats` width is `$clog2(MAX_BEATS+1)`.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — request strobe; sampled only in IDLE.
- `op`  in  1  — 0 = load, 1 = store; sampled with `start`.
- `base`  in  32  — first word address; sampled with `start`.
- `beats`  in  5  — beat count, 0..MAX_BEATS; sampled with `start`.
- `busy`  out  1  — high from the cycle after an accepted `start` until `done`.
- `done`  out  1  — one-cycle pulse at request completion.
- `st_valid` / `st_ready`  in / out  1 / 1  — store-data handshake.
- `st_data`  in  128  — 4 words; word k is bits [32k+31:32k].
- `ld_valid` / `ld_ready`  out / in  1 / 1  — load-data handshake.
- `ld_data`  out  256  — 8 words, same packing.
- `mem_we`  out  1  — memory write enable.
- `mem_wr_addr`, `mem_rd_addr`  out  32 / 32  — memory addresses.
- `mem_wd1`..`mem_wd4`  out  32 each  — memory write data.
- `mem_rd1`..`mem_rd8`  in  32 each  — memory read data; combinational from `mem_rd_addr`.

## Operation
- States: IDLE, STORE, LOAD, FIN.
- IDLE + `start`:
  - Latch `op`, `base` and `beats`; load the address register with `base` and the beat counter with `beats`.
  - `beats`=0: go to FIN directly, with no memory access.
  - Otherwise `op`=1 goes to STORE and `op`=0 goes to LOAD.
  - `start` outside IDLE is ignored.
- STORE:
  - `st_ready`=1. Each `st_valid & st_ready` registers `mem_wd1..4` = words 0..3, `mem_wr_addr` = address register, and `mem_we`=1 for exactly the next cycle.
  - Then: address += 4, counter -= 1. The counter reaching 0 moves to FIN, with `st_ready` low from that cycle on.
  - `mem_we` is 0 in every cycle that does not follow a store handshake.
- LOAD:
  - `mem_rd_addr` is driven from the address register.
  - Capture condition: `ld_valid`=0, or `ld_ready`=1. On capture, `ld_data` <= `{mem_rd8..mem_rd1}`, `ld_valid`=1, address += 8, counter -= 1.
  - After the last capture, go to FIN once that beat is accepted (`ld_valid & ld_ready`).
  - `ld_data` holds stable while `ld_valid & !ld_ready`.
- FIN: `done`=1 for one cycle, `busy`=0 next cycle, return to IDLE.
- Address arithmetic is modulo 2^32; 0xFFFFFFFC + 4 wraps to 0x00000000.
- `beats` > MAX_BEATS is clamped to MAX_BEATS.

## Timing
- Reset values: state IDLE; `busy`, `done`, `st_ready`, `ld_valid` and `mem_we` = 0; all addresses and data outputs = 0.
- `rst` mid-operation returns the block to IDLE on the next edge. Any registered write or held load beat is discarded; there is no `done` pulse.
- `busy` rises in the cycle after `start`. `done` and `busy` never overlap with a new acceptance in the same cycle.
- Store latency: handshake at edge N gives `mem_we`=1 in cycle N+1. Peak throughput is 1 beat/cycle.
- Load latency: the first `ld_valid` comes 2 cycles after `start`. Peak throughput is 1 beat/cycle with `ld_ready` held high.
- Minimum request length, `beats`=n with no back-pressure:
  - Store: n+2 cycles from `start` to `done`.
  - Load: n+2 cycles from `start` to `done`.

## Configuration
- Macro `VEC_MEM_SEQ_STRIDE_EN`.
- Defined: adds input port `stride` (16 bits, unsigned, word units), sampled with `start`. The per-beat address increment is `stride` for both directions, and `stride`=0 re-accesses the same address every beat.
- Undefined: no `stride` port; the increment is fixed at 4 for stores and 8 for loads.

## Test plan
- Store 2 beats, `base`=0, `st_valid` held high with data {50,100,11,23} then {1,2,3,4} -> `mem_we` high 2 cycles; addr 0 then 4; `mem_wd1..4` match each beat in order; one `done` pulse.
- Load 3 beats, `base`=8, `ld_ready`=1, memory preloaded -> `ld_valid` for 3 consecutive cycles; `mem_rd_addr` 8, 16, 24; `ld_data` equals the 8 words at each address.
- Load 2 beats with `ld_ready` low for 3 cycles after the first `ld_valid` -> `ld_data` stable while stalled; exactly 2 beats delivered; `done` only after the second beat is accepted.
- `beats`=0 store, then `start` pulsed while busy on a real request -> zero-beat request gives a `done` pulse with no `mem_we`; the mid-request `start` is ignored, with beat count and addresses unchanged.
- `base`=0xFFFFFFFC, store 2 beats -> addresses 0xFFFFFFFC then 0x00000000.
- `rst` asserted in the cycle after the 1st of 4 store beats -> all outputs return to 0 next edge; no `done`; a subsequent request runs normally.
